// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: adds WIDTH-bit operands CHUNK bits per clock,
// LSB chunk first, through one CHUNK-bit slice with a registered carry.
// Ports: clk, rst (async, active-high); start, a, b, cin, sub in;
//        busy, done (1-cycle pulse), s, cout, ovf out (all registered).
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, s_q;
    logic             carry_q, busy_q, done_q, cout_q, ovf_q;
    logic [IW-1:0]    idx_q;

    logic [CHUNK-1:0] a_ch, b_ch, sum;
    logic             c_out, c_msb;
    logic [WIDTH-1:0] acc_d;

    // Operand registers shift right each RUN cycle, so the active chunk is
    // always in the low bits; the accumulator fills from the top, leaving
    // chunk idx in place once all N chunks have been shifted in.
    always_comb begin
        a_ch          = a_q[CHUNK-1:0];
        b_ch          = b_q[CHUNK-1:0];
        {c_out, sum}  = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
        // carry into the slice MSB recovered from its sum bit
        c_msb         = sum[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
        acc_d         = (acc_q >> CHUNK) | (WIDTH'(sum) << (WIDTH - CHUNK));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= sub | cin;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    acc_q   <= acc_d;
                    carry_q <= c_out;
                    idx_q   <= idx_q + IW'(1);
                    if (idx_q == LAST) begin
                        s_q     <= acc_d;
                        cout_q  <= c_out;
                        ovf_q   <= c_msb ^ c_out;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: three instances (CHUNK=4, 1, 16) share inputs
// and are checked against an arithmetic reference model.
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        rst, start, cin, sub;
    logic [15:0] a, b;

    logic        busy4, done4, cout4, ovf4;
    logic [15:0] s4;
    logic        busy1, done1, cout1, ovf1;
    logic [15:0] s1;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] s16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .sub(sub), .busy(busy4), .done(done4), .s(s4), .cout(cout4),
        .ovf(ovf4));

    seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .sub(sub), .busy(busy1), .done(done1), .s(s1), .cout(cout1),
        .ovf(ovf1));

    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .sub(sub), .busy(busy16), .done(done16), .s(s16), .cout(cout16),
        .ovf(ovf16));

    // Reference: {ovf, cout, s} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] ma, mb,
                                          input logic mcin, msub);
        logic [16:0] full;
        int          sa, sb, r;
        logic        ov;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            full = {1'b0, ma} + {1'b0, ~mb} + 17'd1;
            r    = sa - sb;
        end else begin
            full = {1'b0, ma} + {1'b0, mb} + {16'd0, mcin};
            r    = sa + sb + int'(mcin);
        end
        ov = (r > 32767) || (r < -32768);
        return {ov, full[16], full[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One start pulse; all three instances observed for 20 cycles.
    task automatic run_op(input logic [15:0] ta, tb_, input logic tc, ts);
        logic [17:0] exp;
        logic [17:0] r4, r1, r16;
        logic [15:0] s4p;
        int          l4, l1, l16;
        exp = model(ta, tb_, tc, ts);
        s4p = s4;
        l4 = 0; l1 = 0; l16 = 0;
        r4 = '0; r1 = '0; r16 = '0;
        a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done4 && l4 == 0) begin l4 = c; r4 = {ovf4, cout4, s4}; end
            if (done1 && l1 == 0) begin l1 = c; r1 = {ovf1, cout1, s1}; end
            if (done16 && l16 == 0) begin
                l16 = c; r16 = {ovf16, cout16, s16};
            end
            if (c < 4) begin
                chk("busy4_run", 32'(busy4), 32'd1);
                chk("s4_hold", 32'(s4), 32'(s4p));
            end
            chk("busy_done_excl", 32'(busy4 & done4), 32'd0);
        end
        chk("lat4", l4, 4);
        chk("lat1", l1, 16);
        chk("lat16", l16, 1);
        chk("res4", 32'(r4), 32'(exp));
        chk("res1", 32'(r1), 32'(exp));
        chk("res16", 32'(r16), 32'(exp));
    endtask

    logic [15:0] oa[30], ob[30];
    logic        oc[30], os[30];
    logic [17:0] e;
    logic [15:0] s_last;

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1;
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_done", 32'(done4), 32'd0);
        chk("rst_res", 32'({ovf4, cout4, s4}), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(16'd1060, 16'd11000, 1'b0, 1'b0);
        chk("ex1_s", 32'(s4), 32'd12060);
        run_op(16'd65535, 16'd65535, 1'b1, 1'b0);
        chk("ex2_s", 32'(s4), 32'd65535);
        chk("ex2_cout", 32'(cout4), 32'd1);
        run_op(16'd32767, 16'd1, 1'b0, 1'b0);
        chk("ex3_s", 32'(s4), 32'd32768);
        chk("ex3_ovf", 32'(ovf4), 32'd1);
        run_op(16'd32005, 16'd33533, 1'b1, 1'b1);
        chk("ex4_s", 32'(s4), 32'd64008);
        chk("ex4_cout", 32'(cout4), 32'd0);
        run_op(16'd12500, 16'd3100, 1'b0, 1'b1);
        chk("ex5_s", 32'(s4), 32'd9400);
        chk("ex5_cout", 32'(cout4), 32'd1);
        run_op(16'd65505, 16'd31, 1'b0, 1'b0);
        chk("ex6_s1", 32'(s1), 32'd0);
        chk("ex6_cout16", 32'(cout16), 32'd1);

        for (int i = 0; i < 8; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

        // start held high with fresh operands every cycle
        for (int j = 0; j < 30; j++) begin
            oa[j] = 16'($urandom); ob[j] = 16'($urandom);
            oc[j] = 1'($urandom); os[j] = 1'($urandom);
        end
        s_last = s4;
        for (int j = 0; j < 30; j++) begin
            a = oa[j]; b = ob[j]; cin = oc[j]; sub = os[j]; start = 1'b1;
            @(posedge clk); #1;
            if (j % 5 == 4) begin
                e = model(oa[j-4], ob[j-4], oc[j-4], os[j-4]);
                chk("b2b_done", 32'(done4), 32'd1);
                chk("b2b_res", 32'({ovf4, cout4, s4}), 32'(e));
                s_last = s4;
            end else begin
                chk("b2b_nodone", 32'(done4), 32'd0);
                chk("b2b_hold", 32'(s4), 32'(s_last));
            end
        end
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // async reset during the second RUN cycle
        run_op(16'd40000, 16'd1234, 1'b1, 1'b0);
        a = 16'd500; b = 16'd600; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy4), 32'd0);
        chk("arst_done", 32'(done4), 32'd0);
        chk("arst_res4", 32'({ovf4, cout4, s4}), 32'd0);
        chk("arst_res1", 32'({ovf1, cout1, s1}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("arst_nodone", 32'(done4 | busy4), 32'd0);
        end
        run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
